hazard_scoreboard: RTL

Register scoreboard and hazard controller for the Decode stage. It tracks which architectural registers have an outstanding producer, from the Decode/Issue latch through dispatch to writeback. It drives id_stall to Decode whenever the instruction in decode has a RAW or WAW hazard, and it runs a stall watchdog so the team can detect deadlock between the Decode and Issue stalls.

---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: RAW/WAW stall generation, pending-bit tracking and a stall watchdog.
// Optional macro SB_WB_BYPASS_EN: a same-cycle writeback masks the pending hit for that register.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   id_hd_ass_addra,
    input  logic            id_hd_check_a,
    input  logic [AW-1:0]   id_hd_ass_addrb,
    input  logic            id_hd_check_b,
    input  logic [AW-1:0]   id_ass_waw_write_addr,
    input  logic            id_ass_waw_write_writereg,
    input  logic [AW-1:0]   id_iss_regdest,
    input  logic            id_iss_writereg,
    input  logic            iss_sb_dispatch,
    input  logic [AW-1:0]   iss_sb_addr,
    input  logic            iss_sb_writereg,
    input  logic            wb_sb_valid,
    input  logic [AW-1:0]   wb_sb_addr,
    output logic            id_stall,
    output logic [NREG-1:0] sb_pending,
    output logic [AW:0]     sb_outstanding,
    output logic            sb_timeout
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pendingNext;
    logic [AW:0]     r_outstanding;
    logic [AW:0]     w_countNext;
    logic [TW-1:0]   r_wdCount;
    logic            r_timeout;
    logic            w_set;
    logic            w_clr;
    logic            w_stallRaw;

    // The Decode/Issue latch is an in-flight producer that has not yet reached the pending vector.
    function automatic logic hit(input logic [AW-1:0] x);
        logic w_pend;
        w_pend = r_pending[x];
`ifdef SB_WB_BYPASS_EN
        if (wb_sb_valid && (wb_sb_addr == x))
            w_pend = 1'b0;
`endif
        return (x != '0) && (w_pend || (id_iss_writereg && (id_iss_regdest == x)));
    endfunction

    assign w_set = iss_sb_dispatch && iss_sb_writereg && (iss_sb_addr != '0);
    assign w_clr = wb_sb_valid && (wb_sb_addr != '0);

    always_comb begin
        w_stallRaw = (id_hd_check_a && hit(id_hd_ass_addra))
                  || (id_hd_check_b && hit(id_hd_ass_addrb))
                  || (id_ass_waw_write_writereg && hit(id_ass_waw_write_addr));
    end

    assign id_stall = reset && w_stallRaw;

    // Clear is applied before set so a same-address collision leaves the bit set.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_clr)
            w_pendingNext[wb_sb_addr] = 1'b0;
        if (w_set)
            w_pendingNext[iss_sb_addr] = 1'b1;
        w_pendingNext[0] = 1'b0;
    end

    always_comb begin
        w_countNext = '0;
        for (int i = 0; i < NREG; i++)
            w_countNext = w_countNext + {{AW{1'b0}}, w_pendingNext[i]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending     <= '0;
            r_outstanding <= '0;
        end else begin
            r_pending     <= w_pendingNext;
            r_outstanding <= w_countNext;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdCount <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!id_stall)
                r_wdCount <= '0;
            else if (r_wdCount != '1)
                r_wdCount <= r_wdCount + 1'b1;
            if (id_stall && (r_wdCount == TW'(TIMEOUT - 1)))
                r_timeout <= 1'b1;
        end
    end

    assign sb_pending     = r_pending;
    assign sb_outstanding = r_outstanding;
    assign sb_timeout     = r_timeout;

endmodule
